lc3b_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the LC-3b CPU memory interface.
- Accepts mem_read / mem_write requests with a byte mask, and answers with a one-cycle mem_resp and a 16-bit read word after a fixed, programmable latency.
- Sits opposite the CPU top level, on its memory port, in the system and in benches.
- A side-band init port preloads program/data words.

---
 rtl/lc3b_mem_responder.sv | 155 +++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: fixed-latency read/write with byte lanes,
// a side-band preload port and a sticky protocol-violation flag.
module lc3b_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    output logic                 mem_resp,
    output logic [15:0]          mem_rdata,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [15:0]          init_data,
    output logic                 protocol_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam bit          LAT_ONE = (LATENCY == 1);

    logic [15:0] mem [DEPTH];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 read_q;
    logic [1:0]           mask_q;
    logic [15:0]          wdata_q;
    logic [15:0]          addr_q;
    logic                 resp_q;
    logic [15:0]          rdata_q;
    logic                 err_q;

    logic                 req, held, accept, abort, go_resp;
    logic                 c_read, commit_we;
    logic [ADDR_BITS-1:0] c_idx;
    logic [1:0]           c_mask;
    logic [15:0]          c_wdata;

    assign req  = mem_read | mem_write;
    assign held = read_q ? mem_read : mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        abort   = 1'b0;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LAT_ONE) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_BUSY: begin
                if (!held || (mem_address != addr_q)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY == 1 the commit happens on the acceptance edge, so use the live request.
    always_comb begin
        if (state_q == ST_IDLE) begin
            c_idx   = mem_address[ADDR_BITS:1];
            c_read  = mem_read;
            c_mask  = mem_byte_enable;
            c_wdata = mem_wdata;
        end else begin
            c_idx   = idx_q;
            c_read  = read_q;
            c_mask  = mask_q;
            c_wdata = wdata_q;
        end
    end

    assign commit_we = go_resp & ~c_read & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            read_q  <= 1'b0;
            mask_q  <= 2'b00;
            wdata_q <= 16'h0000;
            addr_q  <= 16'h0000;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= go_resp;
            if (accept) begin
                idx_q   <= mem_address[ADDR_BITS:1];
                read_q  <= mem_read;
                mask_q  <= mem_byte_enable;
                wdata_q <= mem_wdata;
                addr_q  <= mem_address;
            end
            if (go_resp && c_read) begin
                rdata_q <= mem[c_idx];
            end
            if ((accept && mem_read && mem_write) || abort) begin
                err_q <= 1'b1;
            end
        end
    end

    // Later assignments win, so CPU-enabled lanes override a same-edge preload of that word.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        if (commit_we && c_mask[0]) begin
            mem[c_idx][7:0] <= c_wdata[7:0];
        end
        if (commit_we && c_mask[1]) begin
            mem[c_idx][15:8] <= c_wdata[15:8];
        end
    end

    assign mem_resp     = resp_q;
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed protocol cases plus randomized
// transactions checked against an array-based reference model.
module tb_lc3b_mem_responder;

    localparam int unsigned AB  = 8;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [1:0]    be;
    logic [15:0]   addr, wdata;
    logic          resp;
    logic [15:0]   rdata;
    logic          init_we;
    logic [AB-1:0] init_addr;
    logic [15:0]   init_data;
    logic          err;

    logic          r1_read, r1_write;
    logic [1:0]    r1_be;
    logic [15:0]   r1_addr, r1_wdata;
    logic          resp1;
    logic [15:0]   rdata1;
    logic          err1;

    always #5 clk = ~clk;

    lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(be), .mem_address(addr), .mem_wdata(wdata), .mem_resp(resp),
        .mem_rdata(rdata), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .protocol_err(err)
    );

    lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(r1_read), .mem_write(r1_write),
        .mem_byte_enable(r1_be), .mem_address(r1_addr), .mem_wdata(r1_wdata), .mem_resp(resp1),
        .mem_rdata(rdata1), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .protocol_err(err1)
    );

    logic [15:0] model [0:255];
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_init(input int unsigned idx, input logic [15:0] d);
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = idx[AB-1:0];
        init_data = d;
        @(negedge clk);
        init_we   = 1'b0;
        model[idx] = d;
    endtask

    // One complete CPU transaction; the request drops in the response cycle.
    task automatic cpu_txn(input logic rd, input logic wr, input logic [1:0] m,
                           input logic [15:0] a, input logic [15:0] d, input string tag);
        int unsigned idx;
        int          n;
        idx = a[AB:1];
        @(negedge clk);
        mem_read = rd; mem_write = wr; be = m; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp !== 1'b1 && n < 20);
        check({tag, "_latency"}, n, LAT);
        if (rd) begin
            exp_rdata = model[idx];
        end else begin
            if (m[0]) model[idx][7:0]  = d[7:0];
            if (m[1]) model[idx][15:8] = d[15:8];
        end
        if (rd && wr) exp_err = 1'b1;
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, err, exp_err);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, resp, 1'b0);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_resp"}, resp, 1'b0);
        check({tag, "_rdata"}, rdata, 16'h0000);
        check({tag, "_err"}, err, 1'b0);
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n;
        logic [15:0] a, d;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; be = 2'b00; addr = 16'h0000; wdata = 16'h0000;
        init_we = 1'b0; init_addr = '0; init_data = 16'h0000;
        r1_read = 1'b0; r1_write = 1'b0; r1_be = 2'b00; r1_addr = 16'h0000; r1_wdata = 16'h0000;
        exp_rdata = 16'h0000; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_resp", resp, 1'b0);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_err", err, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_no_resp", resp, 1'b0);
        end

        // Preload the whole array so the model is fully defined.
        for (int i = 0; i < 256; i++) do_init(i, 16'($urandom));

        // Read latency and data.
        do_init(5, 16'hBEEF);
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h000A, 16'h0000, "read_w5");
        @(negedge clk);
        r1_read = 1'b1; r1_addr = 16'h000A;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp1 !== 1'b1 && n < 20);
        check("lat1_latency", n, 1);
        check("lat1_rdata", rdata1, 16'hBEEF);
        r1_read = 1'b0;
        @(negedge clk);
        check("lat1_pulse_end", resp1, 1'b0);

        // Byte-masked writes.
        do_init(7, 16'h1234);
        cpu_txn(1'b0, 1'b1, 2'b01, 16'h000E, 16'hABCD, "wr_lo");
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h000E, 16'h0000, "rd_lo");
        check("mask01_value", rdata, 16'h12CD);
        cpu_txn(1'b0, 1'b1, 2'b10, 16'h000E, 16'h5600, "wr_hi");
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h000E, 16'h0000, "rd_hi");
        check("mask10_value", rdata, 16'h56CD);
        cpu_txn(1'b0, 1'b1, 2'b00, 16'h000E, 16'hFFFF, "wr_none");
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h000E, 16'h0000, "rd_none");
        check("mask00_value", rdata, 16'h56CD);

        // Held read: two back-to-back transactions, aliased address 0x0202 -> word 1.
        do_init(1, 16'hC0DE);
        @(negedge clk);
        mem_read = 1'b1; addr = 16'h0202;
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 20 && t2 < 0; i++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                if (t1 < 0) t1 = i;
                else t2 = i;
            end
        end
        mem_read = 1'b0;
        check("b2b_first", t1, LAT);
        check("b2b_spacing", t2 - t1, LAT + 1);
        check("alias_rdata", rdata, 16'hC0DE);
        exp_rdata = 16'hC0DE;
        @(negedge clk);

        // Read and write both high: read wins, no write, flag set.
        do_init(9, 16'h1111);
        cpu_txn(1'b1, 1'b1, 2'b11, 16'h0012, 16'h2222, "both_high");
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h0012, 16'h0000, "both_readback");
        check("both_unchanged", rdata, 16'h1111);

        // Reset during BUSY of a write: nothing committed, no stray response.
        do_init(3, 16'h0001);
        @(negedge clk);
        mem_write = 1'b1; be = 2'b11; addr = 16'h0006; wdata = 16'hFFFF;
        @(negedge clk);
        mid_cycle_reset("rst_busy");
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_stray_resp", resp, 1'b0);
        end
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h0006, 16'h0000, "rst_readback");
        check("rst_word3", rdata, 16'h0001);

        // Write request dropped in BUSY: aborted, flag set.
        @(negedge clk);
        mem_write = 1'b1; be = 2'b11; addr = 16'h0014; wdata = ~model[10];
        @(negedge clk);
        mem_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("drop_no_resp", resp, 1'b0);
        end
        check("drop_err", err, 1'b1);
        exp_err = 1'b1;
        cpu_txn(1'b1, 1'b0, 2'b00, 16'h0014, 16'h0000, "drop_readback");

        // Randomized traffic over a small aliased window.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_init($urandom_range(0, 15), 16'($urandom));
            a = 16'($urandom) & 16'hFE1F;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cpu_txn(1'b1, 1'b0, 2'b00, a, 16'h0000, "rand_rd");
            end else begin
                cpu_txn(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, d, "rand_wr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
